multi_channel_timer: RTL and testbench

Parametrised successor of the single-channel preemption timer. Provides NUM_CH independent quantum timers, each with its own quantum, enable, one-shot/periodic mode and sticky IRQ. Timers are programmed from the decode stage by opcode, with a channel index. Per-channel IRQs are merged into one request plus the lowest-numbered pending channel ID for the scheduler/interrupt logic.

---
 rtl/multi_channel_timer.sv | 173 +++++++++++++++++
 tb/tb_multi_channel_timer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_timer.sv
// multi_channel_timer: NUM_CH independent quantum timers programmed by opcode,
// with per-channel sticky IRQs merged into one request plus a lowest-index ID.
// Optional build macro TIMER_PRESCALER_EN: channels advance only on a shared
// prescaler strobe (every PRESCALE enabled cycles) instead of every enabled cycle.

// One timer channel: quantum/enable/mode registers, counter and sticky IRQ.
module mct_channel #(
   parameter int WIDTH           = 32,
   parameter int DEFAULT_QUANTUM = 100,
   parameter int MIN_QUANTUM     = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             setq,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [WIDTH-1:0] rs_value,
   input  logic             tick_en,
   input  logic             clear,
   output logic [WIDTH-1:0] cnt,
   output logic             irq
);

   logic [WIDTH-1:0] quantum;
   logic             enabled;
   logic             periodic;
   logic             tick;

   // the counter always sees the registered (old) enable, so opcode writes land next cycle
   assign tick = enabled & tick_en;

   // configuration writes, count/expiry and IRQ acknowledge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         quantum  <= WIDTH'(DEFAULT_QUANTUM);
         enabled  <= 1'b0;
         periodic <= 1'b0;
         cnt      <= '0;
         irq      <= 1'b0;
      end else begin
         if (setq && (rs_value > WIDTH'(MIN_QUANTUM)))
            quantum <= rs_value;
         if (mode)
            periodic <= rs_value[0];
         // acknowledge beats a same-cycle expiry and works whether or not ticking
         if (clear) begin
            irq <= 1'b0;
            cnt <= '0;
         end else if (tick && (periodic || !irq)) begin
            // >= rather than == so a lowered quantum expires on the next tick
            if (cnt >= quantum - WIDTH'(1)) begin
               cnt <= '0;
               irq <= 1'b1;
               if (!periodic)
                  enabled <= 1'b0;
            end else begin
               cnt <= cnt + WIDTH'(1);
            end
         end
         // an explicit START/STOP in the same cycle overrides the one-shot self-disable
         if (start)
            enabled <= 1'b1;
         else if (stop)
            enabled <= 1'b0;
      end
   end

endmodule

module multi_channel_timer #(
   parameter int NUM_CH          = 4,
   parameter int WIDTH           = 32,
   parameter int CH_W            = 2,
   parameter int DEFAULT_QUANTUM = 100,
   parameter int MIN_QUANTUM     = 10,
   parameter int PRESCALE        = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [5:0]        opcode,
   input  logic [CH_W-1:0]   ch_sel,
   input  logic [WIDTH-1:0]  rs_value,
   input  logic              enable,
   input  logic [NUM_CH-1:0] clear_irq,
   output logic              irq_out,
   output logic [CH_W-1:0]   irq_id,
   output logic [NUM_CH-1:0] irq_vec,
   output logic [WIDTH-1:0]  counter_out
);

   localparam int NSEL = 1 << CH_W;

   localparam logic [5:0] OP_SETQ  = 6'b100100;
   localparam logic [5:0] OP_START = 6'b100101;
   localparam logic [5:0] OP_STOP  = 6'b100110;
   localparam logic [5:0] OP_MODE  = 6'b100111;

   logic [NSEL-1:0]             ch_ok;
   logic                        hit;
   logic                        strobe;
   logic                        tick_en;
   logic [NUM_CH-1:0][WIDTH-1:0] cnt_all;
   logic [WIDTH-1:0]            cnt_mux [NSEL];

   // table of legal channel indices; avoids a range compare that is constant
   // when NUM_CH is a power of two
   for (genvar j = 0; j < NSEL; j++) begin : g_ok
      assign ch_ok[j] = (j < NUM_CH);
      if (j < NUM_CH) begin : g_live
         assign cnt_mux[j] = cnt_all[j];
      end else begin : g_dead
         assign cnt_mux[j] = '0;
      end
   end

   assign hit = ch_ok[ch_sel];

`ifdef TIMER_PRESCALER_EN
   localparam int PW = $clog2(PRESCALE + 1);

   logic [PW-1:0] presc;

   // shared prescaler: counts 0..PRESCALE-1 on enabled cycles, holds otherwise
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         presc <= '0;
      else if (enable)
         presc <= (presc == PW'(PRESCALE - 1)) ? '0 : presc + PW'(1);
   end

   assign strobe = (presc == PW'(PRESCALE - 1));
`else
   // every enabled cycle is a tick; a zero PRESCALE is illegal in either build
   assign strobe = (PRESCALE >= 1);
`endif

   assign tick_en = enable & strobe;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic sel;
      assign sel = hit && (ch_sel == CH_W'(i));
      mct_channel #(
         .WIDTH           (WIDTH),
         .DEFAULT_QUANTUM (DEFAULT_QUANTUM),
         .MIN_QUANTUM     (MIN_QUANTUM)
      ) u_ch (
         .clock    (clock),
         .reset    (reset),
         .setq     (sel && (opcode == OP_SETQ)),
         .start    (sel && (opcode == OP_START)),
         .stop     (sel && (opcode == OP_STOP)),
         .mode     (sel && (opcode == OP_MODE)),
         .rs_value (rs_value),
         .tick_en  (tick_en),
         .clear    (clear_irq[i]),
         .cnt      (cnt_all[i]),
         .irq      (irq_vec[i])
      );
   end

   assign irq_out     = |irq_vec;
   assign counter_out = cnt_mux[ch_sel];

   // priority encode: scan high to low so the lowest pending index wins
   always_comb begin
      irq_id = '0;
      for (int k = NUM_CH - 1; k >= 0; k--)
         if (irq_vec[k])
            irq_id = CH_W'(k);
   end

endmodule

// File: tb/tb_multi_channel_timer.sv
// Directed bench for multi_channel_timer. Main DUT: 4 channels; a second 3-channel
// instance covers the out-of-range channel index. Prescaler test runs only when
// TIMER_PRESCALER_EN is defined (the cycle-exact tests assume the unscaled build).
module tb_multi_channel_timer;

   localparam logic [5:0] NOP   = 6'b000000;
   localparam logic [5:0] SETQ  = 6'b100100;
   localparam logic [5:0] START = 6'b100101;
   localparam logic [5:0] STOP  = 6'b100110;
   localparam logic [5:0] MODE  = 6'b100111;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  opcode = NOP;
   logic [1:0]  ch_sel = '0;
   logic [31:0] rs_value = '0;
   logic        enable = 1'b0;
   logic [3:0]  clear_irq = '0;
   logic        irq_out;
   logic [1:0]  irq_id;
   logic [3:0]  irq_vec;
   logic [31:0] counter_out;

   logic [5:0]  opcode3 = NOP;
   logic [1:0]  ch_sel3 = '0;
   logic [2:0]  clear3 = '0;
   logic        irq_out3;
   logic [1:0]  irq_id3;
   logic [2:0]  irq_vec3;
   logic [31:0] counter_out3;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clock = ~clock;

   multi_channel_timer #(.NUM_CH(4), .WIDTH(32), .CH_W(2)) u_dut (
      .clock(clock), .reset(reset), .opcode(opcode), .ch_sel(ch_sel),
      .rs_value(rs_value), .enable(enable), .clear_irq(clear_irq),
      .irq_out(irq_out), .irq_id(irq_id), .irq_vec(irq_vec),
      .counter_out(counter_out)
   );

   multi_channel_timer #(.NUM_CH(3), .WIDTH(32), .CH_W(2)) u_dut3 (
      .clock(clock), .reset(reset), .opcode(opcode3), .ch_sel(ch_sel3),
      .rs_value(rs_value), .enable(enable), .clear_irq(clear3),
      .irq_out(irq_out3), .irq_id(irq_id3), .irq_vec(irq_vec3),
      .counter_out(counter_out3)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   // one-cycle opcode on the main DUT; ch_sel is left pointing at the channel
   task automatic op(input logic [5:0] o, input logic [1:0] c, input logic [31:0] v);
      opcode = o; ch_sel = c; rs_value = v;
      step(1);
      opcode = NOP;
   endtask

   task automatic ack(input logic [3:0] m);
      clear_irq = m;
      step(1);
      clear_irq = '0;
   endtask

   initial begin
      #1;
      chk("rst_cnt", counter_out, 0);
      chk("rst_irq_out", {31'd0, irq_out}, 0);
      chk("rst_irq_vec", {28'd0, irq_vec}, 0);
      chk("rst_irq_id", {30'd0, irq_id}, 0);
      step(2);
      reset = 1'b1;
      step(1);

`ifndef TIMER_PRESCALER_EN
      // one-shot ch0, default quantum 100
      enable = 1'b1;
      op(START, 0, 0);
      step(99);
      chk("t1_cnt99", counter_out, 99);
      chk("t1_noirq", {28'd0, irq_vec}, 0);
      step(1);
      chk("t1_irq_vec", {28'd0, irq_vec}, 4'b0001);
      chk("t1_irq_id", {30'd0, irq_id}, 0);
      chk("t1_cnt0", counter_out, 0);
      step(5);
      chk("t1_frozen", counter_out, 0);
      chk("t1_sticky", {31'd0, irq_out}, 1);
      ack(4'b0001);
      chk("t1_cleared", {31'd0, irq_out}, 0);
      step(3);
      chk("t1_disabled", counter_out, 0);

      // periodic ch2, quantum 20; 10 and 8 must be rejected
      op(SETQ, 2, 20);
      op(SETQ, 2, 10);
      op(SETQ, 2, 8);
      op(MODE, 2, 1);
      op(START, 2, 0);
      step(19);
      chk("t2_cnt19", counter_out, 19);
      chk("t2_noirq", {28'd0, irq_vec}, 0);
      step(1);
      chk("t2_irq_vec", {28'd0, irq_vec}, 4'b0100);
      chk("t2_irq_id", {30'd0, irq_id}, 2);
      step(5);
      chk("t2_running", counter_out, 5);
      step(15);
      chk("t2_wrap2", counter_out, 0);
      chk("t2_still_irq", {28'd0, irq_vec}, 4'b0100);
      ack(4'b0100);
      chk("t2_ack_irq", {28'd0, irq_vec}, 0);
      chk("t2_ack_cnt", counter_out, 0);
      step(3);
      chk("t2_after_ack", counter_out, 3);
      op(STOP, 2, 0);
      chk("t2_stop_old_en", counter_out, 4);
      step(3);
      chk("t2_stopped", counter_out, 4);

      // ch1 and ch3 expire on the same edge
      op(SETQ, 1, 15);
      op(SETQ, 3, 14);
      op(START, 1, 0);
      op(START, 3, 0);
      step(13);
      chk("t3_pre_irq", {31'd0, irq_out}, 0);
      chk("t3_cnt3", counter_out, 13);
      step(1);
      chk("t3_irq_vec", {28'd0, irq_vec}, 4'b1010);
      chk("t3_irq_id1", {30'd0, irq_id}, 1);
      ack(4'b0010);
      chk("t3_irq_id3", {30'd0, irq_id}, 3);
      chk("t3_irq_out1", {31'd0, irq_out}, 1);
      ack(4'b1000);
      chk("t3_irq_out0", {31'd0, irq_out}, 0);

      // ch0 quantum 50: stop at 30, enable low, resume
      op(SETQ, 0, 50);
      op(START, 0, 0);
      step(29);
      op(STOP, 0, 0);
      chk("t4_stop30", counter_out, 30);
      step(10);
      chk("t4_hold", counter_out, 30);
      enable = 1'b0;
      op(START, 0, 0);
      step(4);
      chk("t4_en_low", counter_out, 30);
      enable = 1'b1;
      step(19);
      chk("t4_cnt49", counter_out, 49);
      chk("t4_noirq", {28'd0, irq_vec}, 0);
      step(1);
      chk("t4_irq", {28'd0, irq_vec}, 4'b0001);
      ack(4'b0001);

      // clear on the expiring edge wins; channel stays enabled
      op(SETQ, 0, 12);
      op(START, 0, 0);
      step(11);
      chk("t5_cnt11", counter_out, 11);
      ack(4'b0001);
      chk("t5_noirq", {28'd0, irq_vec}, 0);
      chk("t5_cnt0", counter_out, 0);
      step(5);
      chk("t5_counting", counter_out, 5);

      // asynchronous reset between clock edges
      #2 reset = 1'b0;
      #1;
      chk("t6_cnt", counter_out, 0);
      chk("t6_irq_out", {31'd0, irq_out}, 0);
      chk("t6_irq_vec", {28'd0, irq_vec}, 0);
      @(negedge clock);
      reset = 1'b1;
      step(1);
`else
      // prescaler 4, quantum 12: expiry after 48 enabled cycles
      op(SETQ, 0, 12);
      op(START, 0, 0);
      enable = 1'b1;
      step(47);
      chk("p_cnt11", counter_out, 11);
      chk("p_noirq", {28'd0, irq_vec}, 0);
      step(1);
      chk("p_irq", {28'd0, irq_vec}, 4'b0001);
      enable = 1'b0;
`endif

      // 3-channel instance: channel index 3 is out of range and must be ignored
      rs_value = 32'd11;
      opcode3 = SETQ; ch_sel3 = 2'd3;
      step(1);
      opcode3 = START;
      step(1);
      opcode3 = NOP;
      enable = 1'b1;
      step(20);
      chk("oor_irq_vec", {29'd0, irq_vec3}, 0);
      chk("oor_cnt_mux", counter_out3, 0);
      for (int c = 0; c < 3; c++) begin
         ch_sel3 = 2'(c);
         #1;
         chk($sformatf("oor_cnt_ch%0d", c), counter_out3, 0);
      end
`ifndef TIMER_PRESCALER_EN
      opcode3 = START; ch_sel3 = 2'd2;
      step(1);
      opcode3 = NOP;
      step(5);
      chk("oor_ctrl_ch2", counter_out3, 5);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
